// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM state encoding,
// bus widths and the reference truth table of the two-input gate generator.
package tts_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int ROW_W = 2;
    localparam int OUT_W = 3;

    // Generator reference: [2]=xnor(a,b), [1]=nand(a,b), [0]=buf(a)
    function automatic logic [OUT_W-1:0] expected_out(input logic a, input logic b);
        return {~(a ^ b), ~(a & b), a};
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bus between the sweeper and its environment: sweep request/status, the
// stimulus/response pair towards the gate generator and the sample stream.
interface truth_table_sweeper_if;
    import tts_pkg::*;

    logic             start;
    logic [OUT_W-1:0] gen_out;
    logic             a_o;
    logic             b_o;
    logic             busy;
    logic             sample_valid;
    logic [ROW_W-1:0] sample_row;
    logic [OUT_W-1:0] sample_data;
    logic             sample_err;
    logic [2:0]       err_count;
    logic             done;
    logic             pass;

    // Sweeper side
    modport master (
        input  start, gen_out,
        output a_o, b_o, busy, sample_valid, sample_row, sample_data,
               sample_err, err_count, done, pass
    );

    // Environment side (requester + generator)
    modport slave (
        output start, gen_out,
        input  a_o, b_o, busy, sample_valid, sample_row, sample_data,
               sample_err, err_count, done, pass
    );

endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps a/b through rows 0..3, waits SETTLE_CYCLES for
// the generator to settle, samples gen_out and compares it to the expected
// truth table. Reports a per-row sample stream, mismatch count and pass/done.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// DRIVE  | register a_o/b_o from the row index, load the settle counter
// SETTLE | hold a_o/b_o for SETTLE_CYCLES cycles
// SAMPLE | capture gen_out, compare, emit sample strobe, advance row
// DONE   | sweep finished: done pulse visible, pass valid; back to IDLE
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sweeper_if.master  bus
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_t           state;
    state_t           next_state;
    logic [ROW_W-1:0] row;
    logic [CW-1:0]    settle_cnt;
    logic             mismatch;
    logic             last_row;
    logic             settle_last;

    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             valid_q;
    logic [ROW_W-1:0] row_q;
    logic [OUT_W-1:0] data_q;
    logic             err_q;
    logic [2:0]       err_cnt_q;
    logic             done_q;
    logic             pass_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic and row comparison; x/z on gen_out counts as a mismatch
    always_comb begin
        next_state  = state;
        mismatch    = (bus.gen_out !== expected_out(a_q, b_q));
        last_row    = (row == ROW_W'(3));
        settle_last = (settle_cnt == CW'(1));
        case (state)
            IDLE:    if (bus.start) next_state = DRIVE;
            DRIVE:   next_state = SETTLE;
            SETTLE:  if (settle_last) next_state = SAMPLE;
            SAMPLE:  next_state = last_row ? DONE : DRIVE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: stimulus, settle timer, sample stream and sweep result
    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= '0;
            settle_cnt <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            row_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        row       <= '0;
                        err_cnt_q <= '0;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                DRIVE: begin
                    a_q        <= row[1];
                    b_q        <= row[0];
                    settle_cnt <= CW'(SETTLE_CYCLES);
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - CW'(1);
                end
                SAMPLE: begin
                    valid_q <= 1'b1;
                    row_q   <= row;
                    data_q  <= bus.gen_out;
                    err_q   <= mismatch;
                    if (mismatch) err_cnt_q <= err_cnt_q + 3'd1;
                    if (last_row) begin
                        done_q <= 1'b1;
                        pass_q <= (err_cnt_q == 3'd0) && !mismatch;
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.a_o          = a_q;
    assign bus.b_o          = b_q;
    assign bus.busy         = busy_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_row   = row_q;
    assign bus.sample_data  = data_q;
    assign bus.sample_err   = err_q;
    assign bus.err_count    = err_cnt_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;

endmodule
